level_judge: RTL

Parametrised per-level pass/fail arbiter for the symmetry-counter game; sits between the level sequencer (which asserts levelComplete and supplies difference) and display/sound logic.
- Owns the whole game session: current level, remaining lives, tolerance that tightens with level, and win/lose terminal states.
- Judges once per levelComplete rising edge; a held levelComplete is not re-judged.

---
 rtl/level_judge_pkg.sv | 20 ++
 rtl/level_judge_if.sv | 33 +++
 rtl/level_judge_tolerance.sv | 18 +
 rtl/level_judge.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/level_judge_pkg.sv
// Shared types and helpers for the level judge: FSM state encoding and
// the counter-width helper used to size the lives and streak counters.
package judge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAMEOVER,
        ST_WON
    } judge_state_e;

    // Bits needed to hold any value in 0..maxVal (never less than 1).
    function automatic int count_w(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

    localparam int DEF_LIVES   = 3;
    localparam int DEF_LIVES_W = count_w(DEF_LIVES);

endpackage

// File: rtl/level_judge_if.sv
// Bus between the level sequencer (master) and the level judge (slave).
// The master drives start/levelComplete/difference and observes the
// judge's verdict pulses and session status.
interface level_judge_if #(
    parameter int DIFF_W  = 5,
    parameter int LEVEL_W = 4,
    parameter int LIVES_W = 2
);
    logic               start;
    logic               levelComplete;
    logic [DIFF_W-1:0]  difference;
    logic               incLevel;
    logic               miss;
    logic               lose;
    logic               win;
    logic               playing;
    logic [LEVEL_W-1:0] level;
    logic [LIVES_W-1:0] livesLeft;
    logic [DIFF_W-1:0]  tolerance;
    logic               bonusLife;

    modport master (
        output start, levelComplete, difference,
        input  incLevel, miss, lose, win, playing, level, livesLeft,
               tolerance, bonusLife
    );

    modport slave (
        input  start, levelComplete, difference,
        output incLevel, miss, lose, win, playing, level, livesLeft,
               tolerance, bonusLife
    );
endinterface

// File: rtl/level_judge_tolerance.sv
// Combinational level -> passing threshold. The threshold starts at
// BASE_TOL and drops by one every TOL_STEP_LEVELS levels, floored at 0.
// Kept separate so the display block can show the same threshold.
module judge_tolerance #(
    parameter int DIFF_W          = 5,
    parameter int LEVEL_W         = 4,
    parameter int BASE_TOL        = 2,
    parameter int TOL_STEP_LEVELS = 4
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [DIFF_W-1:0]  o_tolerance
);
    logic [31:0] w_drop;

    assign w_drop      = 32'(i_level) / 32'(TOL_STEP_LEVELS);
    assign o_tolerance = (w_drop >= 32'(BASE_TOL)) ? '0
                                                   : DIFF_W'(32'(BASE_TOL) - w_drop);
endmodule

// File: rtl/level_judge.sv
// Per-level pass/fail judge for the symmetry-counter game. Owns the game
// session (level, lives, win/lose) and judges each rising edge of
// levelComplete while playing. Verdicts are registered: an edge sampled
// at one clock shows its pulses during the following cycle.
// Optional feature: define STREAK_BONUS_EN to award a life after
// STREAK_LEN consecutive passes; otherwise bonusLife is tied low.
module level_judge
    import judge_pkg::*;
#(
    parameter int DIFF_W          = 5,
    parameter int LEVEL_W         = 4,
    parameter int MAX_LEVEL       = 15,
    parameter int LIVES           = 3,
    parameter int BASE_TOL        = 2,
    parameter int TOL_STEP_LEVELS = 4,
    parameter int STREAK_LEN      = 3
) (
    input  logic          Clk100M,
    input  logic          Rst_n,
    level_judge_if.slave  jb
);
    localparam int LIVES_W = count_w(LIVES);

    judge_state_e       r_state, w_stateNext;
    logic               r_lcQ;
    logic [LEVEL_W-1:0] r_level, w_levelNext;
    logic [LIVES_W-1:0] r_lives, w_livesNext;
    logic               r_incLevel, w_incNext;
    logic               r_miss, w_missNext;
    logic               r_lose, w_loseNext;
    logic               r_win, w_winNext;
    logic [DIFF_W-1:0]  w_tol;
    logic               w_edge;
    logic               w_pass;

`ifdef STREAK_BONUS_EN
    localparam int STREAK_W = count_w(STREAK_LEN);
    logic [STREAK_W-1:0] r_streak, w_streakNext;
    logic                r_bonus, w_bonusNext;
`endif

    judge_tolerance #(
        .DIFF_W          (DIFF_W),
        .LEVEL_W         (LEVEL_W),
        .BASE_TOL        (BASE_TOL),
        .TOL_STEP_LEVELS (TOL_STEP_LEVELS)
    ) u_tol (
        .i_level     (r_level),
        .o_tolerance (w_tol)
    );

    assign w_edge = jb.levelComplete & ~r_lcQ;
    assign w_pass = (jb.difference <= w_tol);

    // Session registers; the edge detector tracks levelComplete in every state.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= ST_IDLE;
            r_lcQ      <= 1'b0;
            r_level    <= '0;
            r_lives    <= LIVES_W'(LIVES);
            r_incLevel <= 1'b0;
            r_miss     <= 1'b0;
            r_lose     <= 1'b0;
            r_win      <= 1'b0;
`ifdef STREAK_BONUS_EN
            r_streak   <= '0;
            r_bonus    <= 1'b0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_lcQ      <= jb.levelComplete;
            r_level    <= w_levelNext;
            r_lives    <= w_livesNext;
            r_incLevel <= w_incNext;
            r_miss     <= w_missNext;
            r_lose     <= w_loseNext;
            r_win      <= w_winNext;
`ifdef STREAK_BONUS_EN
            r_streak   <= w_streakNext;
            r_bonus    <= w_bonusNext;
`endif
        end
    end

    // Next-state and verdict logic; start overrides any same-cycle judgement.
    always_comb begin
        w_stateNext = r_state;
        w_levelNext = r_level;
        w_livesNext = r_lives;
        w_incNext   = 1'b0;
        w_missNext  = 1'b0;
        w_loseNext  = r_lose;
        w_winNext   = r_win;
`ifdef STREAK_BONUS_EN
        w_streakNext = r_streak;
        w_bonusNext  = 1'b0;
`endif
        if (jb.start) begin
            w_stateNext = ST_PLAY;
            w_levelNext = '0;
            w_livesNext = LIVES_W'(LIVES);
            w_loseNext  = 1'b0;
            w_winNext   = 1'b0;
`ifdef STREAK_BONUS_EN
            w_streakNext = '0;
`endif
        end else if ((r_state == ST_PLAY) && w_edge) begin
            if (w_pass) begin
                w_incNext = 1'b1;
                if (r_level == LEVEL_W'(MAX_LEVEL)) begin
                    w_stateNext = ST_WON;
                    w_winNext   = 1'b1;
                end else begin
                    w_levelNext = r_level + LEVEL_W'(1);
`ifdef STREAK_BONUS_EN
                    if (r_streak == STREAK_W'(STREAK_LEN - 1)) begin
                        w_streakNext = '0;
                        w_bonusNext  = 1'b1;
                        if (r_lives != LIVES_W'(LIVES)) begin
                            w_livesNext = r_lives + LIVES_W'(1);
                        end
                    end else begin
                        w_streakNext = r_streak + STREAK_W'(1);
                    end
`endif
                end
            end else begin
                w_livesNext = r_lives - LIVES_W'(1);
`ifdef STREAK_BONUS_EN
                w_streakNext = '0;
`endif
                if (r_lives == LIVES_W'(1)) begin
                    w_stateNext = ST_GAMEOVER;
                    w_loseNext  = 1'b1;
                end else begin
                    w_missNext = 1'b1;
                end
            end
        end
    end

    assign jb.incLevel  = r_incLevel;
    assign jb.miss      = r_miss;
    assign jb.lose      = r_lose;
    assign jb.win       = r_win;
    assign jb.playing   = (r_state == ST_PLAY);
    assign jb.level     = r_level;
    assign jb.livesLeft = r_lives;
    assign jb.tolerance = w_tol;
`ifdef STREAK_BONUS_EN
    assign jb.bonusLife = r_bonus;
`else
    assign jb.bonusLife = 1'b0;
`endif

endmodule
